// File: rtl/fetch_sequencer_if.sv
// Fetch-path bundle: start/halt control, branch redirect, ROM port and decode handshake.
// No storage; pure wiring between the fetch sequencer and its environment.
// Decode handshake is valid/ready; ROM port is combinational, same-cycle.
interface fetch_sequencer_if #(
  parameter int AW = 8,
  parameter int IW = 24
);
  logic          start;
  logic          halt_req;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          halted;

  // Sequencer side: owns the PC, ROM address and output stage.
  modport master (
    input  start, halt_req, redirect_valid, redirect_addr, rom_data, instr_ready,
    output rom_addr, instr_valid, instr_out, instr_pc, halted
  );

  // Environment side: control, ROM and decode.
  modport slave (
    output start, halt_req, redirect_valid, redirect_addr, rom_data, instr_ready,
    input  rom_addr, instr_valid, instr_out, instr_pc, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the ROM, registers one word for decode.
// Latency: start sampled at edge N enters RUN, first word captured at edge N+1, then 1 word/cycle.
// Backpressure: instr_ready=0 holds the output word, PC and ROM address until the slot frees.
// Optional HALT_OPCODE_EN: a captured word whose top byte equals HALT_OPCODE also halts fetch.
module fetch_sequencer #(
  parameter int           AW          = 8,
  parameter int           IW          = 24,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter logic [7:0]   HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master fs
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] out_q, out_d;
  logic [AW-1:0] ipc_q, ipc_d;
  logic          halted_q, halted_d;

  logic slot_free;
  logic capture;
  logic halt_hit;

  // The output slot can take a new word if it is empty or being drained this cycle.
  assign slot_free = !vld_q || fs.instr_ready;

  // Redirect and halt_req both outrank a capture; redirect additionally flushes the slot.
  assign capture = (state_q == ST_RUN) && slot_free && !fs.halt_req && !fs.redirect_valid;

`ifdef HALT_OPCODE_EN
  // The HALT word itself is still delivered; only subsequent fetches stop.
  assign halt_hit = capture && (fs.rom_data[IW-1:IW-8] == HALT_OPCODE);
`else
  // No opcode decode in this build; keep the parameter referenced for lint.
  logic [7:0] unused_halt_opcode;
  assign unused_halt_opcode = HALT_OPCODE;
  assign halt_hit = 1'b0;
`endif

  // Next-state: redirect > halt_req > capture; state is untouched by a redirect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    out_d   = out_q;
    ipc_d   = ipc_q;

    if (fs.redirect_valid) begin
      pc_d  = fs.redirect_addr;
      vld_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fs.start && !fs.halt_req) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fs.halt_req || halt_hit) state_d = ST_HALTED;
        end
        ST_HALTED: begin
          if (fs.start && !fs.halt_req) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase

      if (capture) begin
        out_d = fs.rom_data;
        ipc_d = pc_q;
        vld_d = 1'b1;
        pc_d  = pc_q + 1'b1;
      end else if (slot_free) begin
        vld_d = 1'b0;
      end
    end

    halted_d = (state_d == ST_HALTED);
  end

  // FSM, PC and output stage registers; halted is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      vld_q    <= 1'b0;
      out_q    <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      out_q    <= out_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
    end
  end

  assign fs.rom_addr    = pc_q;
  assign fs.instr_valid = vld_q;
  assign fs.instr_out   = out_q;
  assign fs.instr_pc    = ipc_q;
  assign fs.halted      = halted_q;

  // A stalled word must not change under decode, and the ROM address must hold with it.
  a_hold_when_busy: assert property (@(posedge clk) disable iff (reset)
    (vld_q && !fs.instr_ready && !fs.redirect_valid)
      |=> ($stable(out_q) && $stable(ipc_q) && $stable(pc_q) && vld_q));

  // halted mirrors the state register.
  a_halted_matches_state: assert property (@(posedge clk) disable iff (reset)
    halted_q == (state_q == ST_HALTED));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM model in the bench, hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge, outputs sampled at the same point.
// Covers reset, streaming, stall, redirect flush, PC wrap, halt/HALT opcode, async reset.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [23:0] rom [0:255];

  fetch_sequencer_if #(.AW(8), .IW(24)) bus ();

  fetch_sequencer #(
    .AW(8), .IW(24), .RESET_PC(8'h00), .HALT_OPCODE(8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fs   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int a = 0; a < 256; a++) rom[a] = 24'(a * 32'h010101);
    rom[255] = 24'h12FFFF;  // keep 0xFF opcode out of the wrap test

    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.halt_req       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 8'h00;
    bus.instr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_vld",    32'(bus.instr_valid), 32'h0);
    check("rst_out",    32'(bus.instr_out),   32'h0);
    check("rst_pc",     32'(bus.instr_pc),    32'h0);
    check("rst_halted", 32'(bus.halted),      32'h0);
    check("rst_addr",   32'(bus.rom_addr),    32'h0);

    // 1: start one cycle, stream 0..3
    bus.start       = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t1_run_novld", 32'(bus.instr_valid), 32'h0);
    check("t1_run_addr",  32'(bus.rom_addr),    32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_vld", 32'(bus.instr_valid), 32'h1);
      check("t1_pc",  32'(bus.instr_pc),    32'(i));
      check("t1_out", 32'(bus.instr_out),   32'(i * 32'h010101));
    end

    // 2: stall on word 4 for three cycles, then resume
    tick();
    check("t2_pc4", 32'(bus.instr_pc), 32'h4);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_vld",  32'(bus.instr_valid), 32'h1);
      check("t2_hold_out",  32'(bus.instr_out),   32'h040404);
      check("t2_hold_pc",   32'(bus.instr_pc),    32'h4);
      check("t2_hold_addr", 32'(bus.rom_addr),    32'h5);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("t2_pc5", 32'(bus.instr_pc), 32'h5);
    tick();
    check("t2_pc6", 32'(bus.instr_pc), 32'h6);

    // 3: redirect to 0x40 with a stalled word pending
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'h40;
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_flush_vld", 32'(bus.instr_valid), 32'h0);
    check("t3_addr",      32'(bus.rom_addr),    32'h40);
    bus.instr_ready = 1'b1;
    tick();
    check("t3_pc40",  32'(bus.instr_pc),  32'h40);
    check("t3_out40", 32'(bus.instr_out), 32'h404040);

    // 4: redirect to 0xFE while ready=1 flushes anyway, then wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'hFE;
    tick();
    bus.redirect_valid = 1'b0;
    check("t4_flush_vld", 32'(bus.instr_valid), 32'h0);
    check("t4_addr",      32'(bus.rom_addr),    32'hFE);
    tick();
    check("t4_pcFE", 32'(bus.instr_pc), 32'hFE);
    tick();
    check("t4_pcFF", 32'(bus.instr_pc), 32'hFF);
    check("t4_wrap_addr", 32'(bus.rom_addr), 32'h0);
    tick();
    check("t4_pc00",  32'(bus.instr_pc),  32'h0);
    check("t4_out00", 32'(bus.instr_out), 32'h0);

    // 5: HALT opcode at address 3
    rom[3] = 24'hFF0000;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'h03;
    tick();
    bus.redirect_valid = 1'b0;
    check("t5_addr3", 32'(bus.rom_addr), 32'h3);
    tick();
    check("t5_pc3",  32'(bus.instr_pc),    32'h3);
    check("t5_vld3", 32'(bus.instr_valid), 32'h1);
    check("t5_out3", 32'(bus.instr_out),   32'hFF0000);
`ifdef HALT_OPCODE_EN
    check("t5_halted",    32'(bus.halted),   32'h1);
    check("t5_addr4",     32'(bus.rom_addr), 32'h4);
    tick();
    check("t5_nocap_vld", 32'(bus.instr_valid), 32'h0);
    check("t5_hold_addr", 32'(bus.rom_addr),    32'h4);
    check("t5_still_hlt", 32'(bus.halted),      32'h1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5_resume_hlt", 32'(bus.halted), 32'h0);
    tick();
    check("t5_pc4", 32'(bus.instr_pc),    32'h4);
    check("t5_vld4", 32'(bus.instr_valid), 32'h1);
`else
    check("t5_nohalt", 32'(bus.halted), 32'h0);
    tick();
    check("t5_pc4",  32'(bus.instr_pc),    32'h4);
    check("t5_vld4", 32'(bus.instr_valid), 32'h1);
`endif

    // halt_req with a stalled word: word stays presented, state halts
    bus.instr_ready = 1'b0;
    bus.halt_req    = 1'b1;
    tick();
    check("h_halted",  32'(bus.halted),      32'h1);
    check("h_keep_vld", 32'(bus.instr_valid), 32'h1);
    check("h_keep_pc", 32'(bus.instr_pc),    32'h4);
    // start together with halt_req: halt wins; pending word drains
    bus.instr_ready = 1'b1;
    bus.start       = 1'b1;
    tick();
    check("h_sim_halted", 32'(bus.halted),      32'h1);
    check("h_drain_vld",  32'(bus.instr_valid), 32'h0);
    bus.halt_req = 1'b0;
    tick();
    bus.start = 1'b0;
    check("h_resume", 32'(bus.halted),      32'h0);
    check("h_nocap",  32'(bus.instr_valid), 32'h0);
    tick();
    check("h_pc5", 32'(bus.instr_pc), 32'h5);

    // 6: async reset between edges mid-RUN
    check("t6_pre_vld", 32'(bus.instr_valid), 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_vld",  32'(bus.instr_valid), 32'h0);
    check("t6_rst_addr", 32'(bus.rom_addr),    32'h0);
    check("t6_rst_hlt",  32'(bus.halted),      32'h0);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t6_run_novld", 32'(bus.instr_valid), 32'h0);
    tick();
    check("t6_pc0",  32'(bus.instr_pc),    32'h0);
    check("t6_vld0", 32'(bus.instr_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
